// File: rtl/ycbcr_rgb565.sv
// ycbcr_rgb565 : YCbCr 8:8:8 (full-range, offset-binary chroma) to RGB565.
// BT.601 full-range inverse transform with 8-bit fractional coefficients.
// The three-stage pipeline runs every clock. The frame sync signals are
// delayed by the same three clocks, so sync and pixel data leave together.
//
// Parameters
//   BLANK_ZERO : 1 = force RGB outputs to 0 while post_frame_href is low
//
// Ports
//   clk                 in   pixel clock
//   rst                 in   synchronous active-high reset (clears everything)
//   img_Y/img_Cb/img_Cr in   8-bit luma / chroma (chroma 128 = zero)
//   per_frame_clken     in   pixel valid
//   per_frame_vsync     in   frame sync
//   per_frame_href      in   line valid
//   cmos_R/G/B          out  RGB565 pixel, 3 clk after input
//   post_frame_*        out  sync inputs delayed by 3 clk
module ycbcr_rgb565 #(
  parameter int BLANK_ZERO = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] img_Y,
  input  logic [7:0] img_Cb,
  input  logic [7:0] img_Cr,
  input  logic       per_frame_clken,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  output logic [4:0] cmos_R,
  output logic [5:0] cmos_G,
  output logic [4:0] cmos_B,
  output logic       post_frame_clken,
  output logic       post_frame_vsync,
  output logic       post_frame_href
);

  // 20 bits covers every product and sum (largest magnitude is about 123k)
  localparam int SUM_W = 20;
  localparam logic signed [SUM_W-1:0] C_R   = SUM_W'(359);
  localparam logic signed [SUM_W-1:0] C_GB  = SUM_W'(88);
  localparam logic signed [SUM_W-1:0] C_GR  = SUM_W'(183);
  localparam logic signed [SUM_W-1:0] C_B   = SUM_W'(454);
  localparam logic signed [SUM_W-1:0] C_OFS = SUM_W'(128);
  localparam logic signed [SUM_W-1:0] C_RND = SUM_W'(128);

  // Floor-shift by 8, then saturate to 0..255. Each function keeps only
  // the bits that survive the RGB565 pack.
  function automatic logic [4:0] sat_pack5(input logic signed [SUM_W-1:0] full);
    logic signed [SUM_W-1:0] s;
    s = full >>> 8;
    if (s < C_OFS - C_OFS)        return 5'd0;
    else if (s > SUM_W'(255))     return 5'h1f;
    else                          return s[7:3];
  endfunction

  function automatic logic [5:0] sat_pack6(input logic signed [SUM_W-1:0] full);
    logic signed [SUM_W-1:0] s;
    s = full >>> 8;
    if (s < C_OFS - C_OFS)        return 6'd0;
    else if (s > SUM_W'(255))     return 6'h3f;
    else                          return s[7:2];
  endfunction

  logic signed [SUM_W-1:0] dcb, dcr;
  logic signed [SUM_W-1:0] pr_p0_d, pgb_p0_d, pgr_p0_d, pb_p0_d;
  logic signed [SUM_W-1:0] pr_p0_q, pgb_p0_q, pgr_p0_q, pb_p0_q;
  logic [7:0]              y_p0_q;
  logic signed [SUM_W-1:0] y_ext;
  logic signed [SUM_W-1:0] r_p1_d, g_p1_d, b_p1_d;
  logic signed [SUM_W-1:0] r_p1_q, g_p1_q, b_p1_q;
  logic [4:0]              r_p2_d, b_p2_d, r_p2_q, b_p2_q;
  logic [5:0]              g_p2_d, g_p2_q;
  logic vld_p0_q, vld_p1_q, vld_p2_q;
  logic href_p0_q, href_p1_q, href_p2_q;
  logic vsync_p0_q, vsync_p1_q, vsync_p2_q;

  // ---- stage p0: chroma offsets and coefficient products ----
  always_comb begin
    dcb      = $signed({{(SUM_W-8){1'b0}}, img_Cb}) - C_OFS;
    dcr      = $signed({{(SUM_W-8){1'b0}}, img_Cr}) - C_OFS;
    pr_p0_d  = dcr * C_R;
    pgb_p0_d = dcb * C_GB;
    pgr_p0_d = dcr * C_GR;
    pb_p0_d  = dcb * C_B;
  end

  // ---- stage p1: luma plus chroma contributions, rounding bias added ----
  always_comb begin
    y_ext  = $signed({{(SUM_W-16){1'b0}}, y_p0_q, 8'd0});
    r_p1_d = y_ext + pr_p0_q + C_RND;
    g_p1_d = y_ext - pgb_p0_q - pgr_p0_q + C_RND;
    b_p1_d = y_ext + pb_p0_q + C_RND;
  end

  // ---- stage p2: floor shift, saturate, truncate to RGB565 ----
  always_comb begin
    r_p2_d = sat_pack5(r_p1_q);
    g_p2_d = sat_pack6(g_p1_q);
    b_p2_d = sat_pack5(b_p1_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pr_p0_q    <= '0;
      pgb_p0_q   <= '0;
      pgr_p0_q   <= '0;
      pb_p0_q    <= '0;
      y_p0_q     <= '0;
      r_p1_q     <= '0;
      g_p1_q     <= '0;
      b_p1_q     <= '0;
      r_p2_q     <= '0;
      g_p2_q     <= '0;
      b_p2_q     <= '0;
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      href_p0_q  <= 1'b0;
      href_p1_q  <= 1'b0;
      href_p2_q  <= 1'b0;
      vsync_p0_q <= 1'b0;
      vsync_p1_q <= 1'b0;
      vsync_p2_q <= 1'b0;
    end else begin
      pr_p0_q    <= pr_p0_d;
      pgb_p0_q   <= pgb_p0_d;
      pgr_p0_q   <= pgr_p0_d;
      pb_p0_q    <= pb_p0_d;
      y_p0_q     <= img_Y;
      r_p1_q     <= r_p1_d;
      g_p1_q     <= g_p1_d;
      b_p1_q     <= b_p1_d;
      r_p2_q     <= r_p2_d;
      g_p2_q     <= g_p2_d;
      b_p2_q     <= b_p2_d;
      vld_p0_q   <= per_frame_clken;
      vld_p1_q   <= vld_p0_q;
      vld_p2_q   <= vld_p1_q;
      href_p0_q  <= per_frame_href;
      href_p1_q  <= href_p0_q;
      href_p2_q  <= href_p1_q;
      vsync_p0_q <= per_frame_vsync;
      vsync_p1_q <= vsync_p0_q;
      vsync_p2_q <= vsync_p1_q;
    end
  end

  // Blanking gates the registered pixel with the registered href, so the
  // last pixel of a line still leaves with href high.
  assign cmos_R = (BLANK_ZERO != 0 && !href_p2_q) ? 5'd0 : r_p2_q;
  assign cmos_G = (BLANK_ZERO != 0 && !href_p2_q) ? 6'd0 : g_p2_q;
  assign cmos_B = (BLANK_ZERO != 0 && !href_p2_q) ? 5'd0 : b_p2_q;

  assign post_frame_clken = vld_p2_q;
  assign post_frame_href  = href_p2_q;
  assign post_frame_vsync = vsync_p2_q;

endmodule

// File: tb/tb_ycbcr_rgb565.sv
module tb_ycbcr_rgb565;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] img_Y, img_Cb, img_Cr;
  logic       ck_i, hr_i, vs_i;
  logic [4:0] r0, b0, r1, b1;
  logic [5:0] g0, g1;
  logic       pc0, pv0, ph0, pc1, pv1, ph1;

  ycbcr_rgb565 #(.BLANK_ZERO(1)) u_dut (
    .clk(clk), .rst(rst), .img_Y(img_Y), .img_Cb(img_Cb), .img_Cr(img_Cr),
    .per_frame_clken(ck_i), .per_frame_vsync(vs_i), .per_frame_href(hr_i),
    .cmos_R(r0), .cmos_G(g0), .cmos_B(b0),
    .post_frame_clken(pc0), .post_frame_vsync(pv0), .post_frame_href(ph0));

  ycbcr_rgb565 #(.BLANK_ZERO(0)) u_raw (
    .clk(clk), .rst(rst), .img_Y(img_Y), .img_Cb(img_Cb), .img_Cr(img_Cr),
    .per_frame_clken(ck_i), .per_frame_vsync(vs_i), .per_frame_href(hr_i),
    .cmos_R(r1), .cmos_G(g1), .cmos_B(b1),
    .post_frame_clken(pc1), .post_frame_vsync(pv1), .post_frame_href(ph1));

  typedef struct packed {
    logic [15:0] rgb;
    logic        ck;
    logic        hr;
    logic        vs;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: real BT.601 equation in integer form, floor division.
  function automatic int fdiv256(input int v);
    if (v >= 0) return v / 256;
    return -((-v + 255) / 256);
  endfunction

  function automatic int clamp8(input int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic logic [15:0] model_rgb(input int y, input int cb, input int cr);
    int r, g, b;
    logic [15:0] o;
    r = clamp8(fdiv256(y * 256 + 359 * (cr - 128) + 128));
    g = clamp8(fdiv256(y * 256 - 88 * (cb - 128) - 183 * (cr - 128) + 128));
    b = clamp8(fdiv256(y * 256 + 454 * (cb - 128) + 128));
    o[15:11] = 5'(r / 8);
    o[10:5]  = 6'(g / 4);
    o[4:0]   = 5'(b / 8);
    return o;
  endfunction

  // One clock: drive at negedge, push expectation, sample 1 ns after posedge.
  // The queue holds what the pipeline owes: two in-flight entries plus this one.
  task automatic step(input int y, input int cb, input int cr,
                      input logic c, input logic h, input logic v, input logic r,
                      output logic [37:0] act, output logic [37:0] exp);
    exp_t e;
    exp_t z;
    @(negedge clk);
    rst    = r;
    img_Y  = y[7:0];
    img_Cb = cb[7:0];
    img_Cr = cr[7:0];
    ck_i   = c;
    hr_i   = h;
    vs_i   = v;
    e.rgb  = model_rgb(y, cb, cr);
    e.ck   = c;
    e.hr   = h;
    e.vs   = v;
    q.push_back(e);
    @(posedge clk);
    #1;
    z = '0;
    if (r) begin
      q.delete();
      e = z;
      q.push_back(z);
      q.push_back(z);
    end else begin
      e = q.pop_front();
    end
    act = {r0, g0, b0, pc0, ph0, pv0, r1, g1, b1, pc1, ph1, pv1};
    exp = {(e.hr ? e.rgb : 16'h0), e.ck, e.hr, e.vs, e.rgb, e.ck, e.hr, e.vs};
  endtask

  task automatic test_reset();
    logic [37:0] a, e;
    for (int i = 0; i < 3; i++) begin
      step($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           1'b1, 1'b1, 1'b1, 1'b1, a, e);
      total++;
      if (a !== 38'd0) begin
        bad++;
        $display("FAIL reset[%0d] got=%h want=%h", i, a, 38'd0);
      end
    end
  endtask

  // Known points: grey, white, black, primary red, and both clamp directions.
  task automatic test_known_points();
    int ty[6]  = '{128, 255, 0,  76, 255,   0};
    int tcb[6] = '{128, 128, 128, 85, 128, 128};
    int tcr[6] = '{128, 128, 128, 255, 255,  0};
    logic [15:0] want[6];
    logic [37:0] a, e;
    want[0] = {5'd16, 6'd32, 5'd16};
    want[1] = {5'd31, 6'd63, 5'd31};
    want[2] = {5'd0,  6'd0,  5'd0};
    want[3] = {5'd31, 6'd0,  5'd0};
    want[4] = {5'd31, 6'd41, 5'd31};
    want[5] = {5'd0,  6'd23, 5'd0};
    for (int i = 0; i < 8; i++) begin
      if (i < 6) step(ty[i], tcb[i], tcr[i], 1'b1, 1'b1, 1'b0, 1'b0, a, e);
      else       step(0, 128, 128, 1'b0, 1'b0, 1'b0, 1'b0, a, e);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL known_model[%0d] got=%h want=%h", i, a, e);
      end
      if (i >= 2) begin
        total++;
        if ({r0, g0, b0, ph0} !== {want[i-2], 1'b1}) begin
          bad++;
          $display("FAIL known_const[%0d] got=%h want=%h", i - 2, {r0, g0, b0, ph0}, {want[i-2], 1'b1});
        end
      end
    end
  endtask

  // vsync pulse, 4-pixel line, gap, vsync pulse; pixel data never idle.
  task automatic test_sync_line();
    logic [2:0] pat[14];
    logic [37:0] a, e;
    pat = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b110, 3'b110, 3'b110, 3'b110,
            3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
    for (int i = 0; i < 14; i++) begin
      step($urandom_range(1, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           pat[i][2], pat[i][1], pat[i][0], 1'b0, a, e);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL sync_line[%0d] got=%h want=%h", i, a, e);
      end
      if (i >= 2) begin
        total++;
        if ({pc0, ph0, pv0} !== pat[i-2] || (!ph0 && {r0, g0, b0} !== 16'h0)) begin
          bad++;
          $display("FAIL sync_delay[%0d] got=%b/%h want=%b/blank", i, {pc0, ph0, pv0}, {r0, g0, b0}, pat[i-2]);
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [37:0] a, e;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) step(60 + 40 * i, 100 + 10 * i, 200 - 20 * i, 1'b1, 1'b1, 1'b0, (i == 1), a, e);
      else       step(0, 128, 128, 1'b0, 1'b0, 1'b0, 1'b0, a, e);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL reset_mid[%0d] got=%h want=%h", i, a, e);
      end
      if (i == 1) begin
        total++;
        if (a !== 38'd0) begin
          bad++;
          $display("FAIL reset_mid_zero got=%h want=%h", a, 38'd0);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] a, e;
    logic h;
    for (int i = 0; i < 40; i++) begin
      h = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           h, h, ($urandom_range(0, 9) == 0), 1'b0, a, e);
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL back_to_back[%0d] got=%h want=%h", i, a, e);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    img_Y  = '0;
    img_Cb = '0;
    img_Cr = '0;
    ck_i   = 1'b0;
    hr_i   = 1'b0;
    vs_i   = 1'b0;
    test_reset();
    test_known_points();
    test_sync_line();
    test_reset_midline();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
